// File: rtl/dc_pkg.sv
// Shared encodings and widths for the 14-bit PID datapath.
// Mux select codes follow the FSM's microcode field layout.
package dc_pkg;

    localparam int DC_W  = 14;
    localparam int DC_PW = 2*DC_W + 1;

    localparam logic [DC_W-1:0] DC_CONST_K = 14'h0A5A;
    localparam logic [DC_W-1:0] DC_MAX     = 14'h1FFF;
    localparam logic [DC_W-1:0] DC_MIN     = 14'h2000;

    typedef enum logic [2:0] {
        ASEL_CFGDATA = 3'd0,
        ASEL_XMEAS   = 3'd1,
        ASEL_ERR     = 3'd2,
        ASEL_PROD    = 3'd3,
        ASEL_DUTY    = 3'd4,
        ASEL_SUMERR  = 3'd5,
        ASEL_DIFERR  = 3'd6,
        ASEL_ZERO    = 3'd7
    } asel_e;

    typedef enum logic [2:0] {
        BSEL_XSET    = 3'd0,
        BSEL_SUMERR  = 3'd1,
        BSEL_PREVERR = 3'd2,
        BSEL_ZERO    = 3'd3,
        BSEL_PID     = 3'd4,
        BSEL_CONST   = 3'd5,
        BSEL_PROD    = 3'd6,
        BSEL_EEPDATA = 3'd7
    } bsel_e;

    // Clamp a 15-bit signed sum into the 14-bit signed range.
    function automatic logic [DC_W-1:0] sat_w(input logic [DC_W:0] s);
        if (s[DC_W] != s[DC_W-1])
            return s[DC_W] ? DC_MIN : DC_MAX;
        return s[DC_W-1:0];
    endfunction

endpackage

// File: rtl/dc_alu.sv
// Shared 15-bit adder/subtractor for the PID datapath.
// Build option DC_ALU_SAT_EN: saturate the 14-bit result instead of wrapping.
module dc_alu
    import dc_pkg::*;
(
    input  logic [DC_W-1:0] i_a,
    input  logic [DC_W-1:0] i_b,
    input  logic            i_subtract,
    input  logic            i_wrap,
    output logic [DC_W:0]   o_sum,
    output logic [DC_W-1:0] o_dst
);

    logic [DC_W:0] w_a;
    logic [DC_W:0] w_b;

    assign w_a   = {i_a[DC_W-1], i_a};
    assign w_b   = {i_b[DC_W-1], i_b};
    assign o_sum = i_subtract ? (w_a - w_b) : (w_a + w_b);

`ifdef DC_ALU_SAT_EN
    // Booth steps must see the raw sum; only general arithmetic clamps.
    assign o_dst = i_wrap ? o_sum[DC_W-1:0] : sat_w(o_sum);
`else
    logic w_unused_wrap;
    assign w_unused_wrap = i_wrap;
    assign o_dst         = o_sum[DC_W-1:0];
`endif

endmodule

// File: rtl/dc_datapath_core.sv
// PID arithmetic datapath: operand muxes, working registers and Booth product register.
// Build option DC_ALU_SAT_EN selects saturating add/sub in dc_alu.
module dc_datapath_core
    import dc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DC_W-1:0] eep_rd_data,
    input  logic [DC_W-1:0] xmeas,
    input  logic [DC_W-1:0] cfg_data,
    input  logic [2:0]      c_asel,
    input  logic [2:0]      c_bsel,
    input  logic            c_subtract,
    input  logic            c_err,
    input  logic            c_duty,
    input  logic            c_sumerr,
    input  logic            c_diferr,
    input  logic            c_xset,
    input  logic            c_preverr,
    input  logic            c_pid,
    input  logic            c_init_prod,
    input  logic            c_multsat,
    input  logic            c_clr_duty,
    output logic [DC_W-1:0] dst,
    output logic [1:0]      c_prod
);

    logic [DC_W-1:0]  r_err;
    logic [DC_W-1:0]  r_duty;
    logic [DC_W-1:0]  r_sumerr;
    logic [DC_W-1:0]  r_diferr;
    logic [DC_W-1:0]  r_xset;
    logic [DC_W-1:0]  r_preverr;
    logic [DC_W-1:0]  r_pid;
    logic [DC_PW-1:0] r_prod;

    logic [DC_W-1:0]  w_a;
    logic [DC_W-1:0]  w_b;
    logic [DC_W:0]    w_sum;
    logic [DC_W-1:0]  w_prod_hi;
    logic [DC_W-1:0]  w_prod_q11;
    logic [DC_W-1:0]  w_prod_sat;
    logic             w_booth_step;
    logic             w_q11_fits;

    assign w_booth_step = (asel_e'(c_asel) == ASEL_PROD);
    assign w_prod_hi    = r_prod[DC_PW-1:DC_W+1];
    assign w_prod_q11   = r_prod[25:12];

    // P>>>11 fits in 14 bits only when the four top product bits agree.
    assign w_q11_fits = (&r_prod[28:25]) | ~(|r_prod[28:25]);
    assign w_prod_sat = w_q11_fits ? w_prod_q11 : (r_prod[28] ? DC_MIN : DC_MAX);

    always_comb begin
        w_a = '0;
        case (asel_e'(c_asel))
            ASEL_CFGDATA: w_a = cfg_data;
            ASEL_XMEAS:   w_a = xmeas;
            ASEL_ERR:     w_a = r_err;
            ASEL_PROD:    w_a = w_prod_hi;
            ASEL_DUTY:    w_a = r_duty;
            ASEL_SUMERR:  w_a = r_sumerr;
            ASEL_DIFERR:  w_a = r_diferr;
            ASEL_ZERO:    w_a = '0;
            default:      w_a = '0;
        endcase
    end

    always_comb begin
        w_b = '0;
        if (c_multsat) begin
            w_b = w_prod_sat;
        end else begin
            case (bsel_e'(c_bsel))
                BSEL_XSET:    w_b = r_xset;
                BSEL_SUMERR:  w_b = r_sumerr;
                BSEL_PREVERR: w_b = r_preverr;
                BSEL_ZERO:    w_b = '0;
                BSEL_PID:     w_b = r_pid;
                BSEL_CONST:   w_b = DC_CONST_K;
                BSEL_PROD:    w_b = w_prod_q11;
                BSEL_EEPDATA: w_b = eep_rd_data;
                default:      w_b = '0;
            endcase
        end
    end

    dc_alu u_alu (
        .i_a        (w_a),
        .i_b        (w_b),
        .i_subtract (c_subtract),
        .i_wrap     (w_booth_step),
        .o_sum      (w_sum),
        .o_dst      (dst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= '0;
            r_duty    <= '0;
            r_sumerr  <= '0;
            r_diferr  <= '0;
            r_xset    <= '0;
            r_preverr <= '0;
            r_pid     <= '0;
        end else begin
            if (c_err)     r_err     <= dst;
            if (c_sumerr)  r_sumerr  <= dst;
            if (c_diferr)  r_diferr  <= dst;
            if (c_xset)    r_xset    <= dst;
            if (c_preverr) r_preverr <= dst;
            if (c_pid)     r_pid     <= dst;
            if (c_clr_duty)
                r_duty <= '0;
            else if (c_duty)
                r_duty <= dst;
        end
    end

    // Booth step: the full 15-bit sum becomes the new upper half, shifting the multiplier right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prod <= '0;
        else if (c_init_prod)
            r_prod <= {{DC_W{1'b0}}, dst, 1'b0};
        else if (w_booth_step)
            r_prod <= {w_sum, r_prod[DC_W:1]};
    end

    assign c_prod = r_prod[1:0];

endmodule

// File: tb/tb_dc_datapath_core.sv
// Scoreboard bench for dc_datapath_core: integer reference model, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_dc_datapath_core;

`ifdef DC_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] eep_rd_data, xmeas, cfg_data;
    logic [2:0]  c_asel, c_bsel;
    logic        c_subtract, c_err, c_duty, c_sumerr, c_diferr, c_xset, c_preverr, c_pid;
    logic        c_init_prod, c_multsat, c_clr_duty;
    logic [13:0] dst;
    logic [1:0]  c_prod;

    always #5 clk = ~clk;

    dc_datapath_core dut (
        .clk(clk), .rst_n(rst_n), .eep_rd_data(eep_rd_data), .xmeas(xmeas), .cfg_data(cfg_data),
        .c_asel(c_asel), .c_bsel(c_bsel), .c_subtract(c_subtract), .c_err(c_err), .c_duty(c_duty),
        .c_sumerr(c_sumerr), .c_diferr(c_diferr), .c_xset(c_xset), .c_preverr(c_preverr),
        .c_pid(c_pid), .c_init_prod(c_init_prod), .c_multsat(c_multsat), .c_clr_duty(c_clr_duty),
        .dst(dst), .c_prod(c_prod)
    );

    typedef struct {
        string       name;
        bit          chk_dst;
        logic [13:0] exp_dst;
        bit          chk_prod;
        logic [1:0]  exp_prod;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    logic tb_chk = 1'b0;

    // Reference state: 0 err, 1 duty, 2 sumerr, 3 diferr, 4 xset, 5 preverr, 6 pid
    logic [13:0] m_r [7];
    int          m_mcand, m_mplier, m_steps;

    function automatic int sx(input logic [13:0] v);
        return v[13] ? int'(v) - 16384 : int'(v);
    endfunction

    function automatic logic [13:0] clamp14(input int v);
        if (v > 8191)  return 14'h1FFF;
        if (v < -8192) return 14'h2000;
        return v[13:0];
    endfunction

    function automatic logic [13:0] alu_res(input int s, input bit wrap);
        if (SAT && !wrap) return clamp14(s);
        return s[13:0];
    endfunction

    function automatic int m_p();
        return m_mcand * m_mplier;
    endfunction

    function automatic logic [13:0] q11_sat();
        return clamp14(m_p() >>> 11);
    endfunction

    function automatic logic [13:0] q11_wrap();
        int q;
        q = m_p() >>> 11;
        return q[13:0];
    endfunction

    // Recode pair {y[k], y[k-1]} after k steps; once done, prod[1:0] holds {P[0], y[13]}.
    function automatic logic [1:0] m_cprod();
        logic [13:0] y;
        int          p;
        y = m_mplier[13:0];
        if (m_steps >= 14) begin
            p = m_p();
            return {p[0], y[13]};
        end
        if (m_steps == 0) return {y[0], 1'b0};
        return {y[m_steps], y[m_steps-1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_r[i] = '0;
        m_mcand  = 0;
        m_mplier = 0;
        m_steps  = 14;
    endtask

    task automatic drive(input string nm, input logic [2:0] asel, input logic [2:0] bsel,
                         input bit sub, input logic [6:0] ld, input bit init, input bit msat,
                         input bit clr, input bit chk_d, input bit chk_p);
        exp_t        e;
        int          a, b, s;
        logic [13:0] d;
        c_asel = asel; c_bsel = bsel; c_subtract = sub;
        c_err = ld[0]; c_duty = ld[1]; c_sumerr = ld[2]; c_diferr = ld[3];
        c_xset = ld[4]; c_preverr = ld[5]; c_pid = ld[6];
        c_init_prod = init; c_multsat = msat; c_clr_duty = clr;
        case (asel)
            3'd0: a = sx(cfg_data);
            3'd1: a = sx(xmeas);
            3'd2: a = sx(m_r[0]);
            3'd4: a = sx(m_r[1]);
            3'd5: a = sx(m_r[2]);
            3'd6: a = sx(m_r[3]);
            default: a = 0;
        endcase
        if (msat) b = sx(q11_sat());
        else begin
            case (bsel)
                3'd0: b = sx(m_r[4]);
                3'd1: b = sx(m_r[2]);
                3'd2: b = sx(m_r[5]);
                3'd4: b = sx(m_r[6]);
                3'd5: b = 2650;
                3'd6: b = sx(q11_wrap());
                3'd7: b = sx(eep_rd_data);
                default: b = 0;
            endcase
        end
        s = sub ? a - b : a + b;
        d = alu_res(s, asel == 3'd3);
        e.name = nm; e.chk_dst = chk_d; e.exp_dst = d; e.chk_prod = chk_p; e.exp_prod = m_cprod();
        sb_q.push_back(e);
        tb_chk = 1'b1;
        if (init) begin
            m_mcand  = sx(m_r[6]);
            m_mplier = sx(d);
            m_steps  = 0;
        end else if (asel == 3'd3 && m_steps < 14) begin
            m_steps++;
        end
        for (int i = 0; i < 7; i++) if (ld[i]) m_r[i] = d;
        if (clr) m_r[1] = '0;
        @(posedge clk);
        #1;
        tb_chk = 1'b0;
    endtask

    task automatic mult(input logic [13:0] mc, input logic [13:0] mp, input int nsteps);
        logic [1:0] cp;
        eep_rd_data = mc;
        drive("mul_pid", 3'd7, 3'd7, 1'b0, 7'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xmeas = mp;
        drive("mul_err", 3'd1, 3'd3, 1'b0, 7'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("mul_init", 3'd2, 3'd3, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < nsteps; i++) begin
            cp = m_cprod();
            if (cp == 2'b10)      drive("booth", 3'd3, 3'd4, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else if (cp == 2'b01) drive("booth", 3'd3, 3'd4, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            else                  drive("booth", 3'd3, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (nsteps == 14) begin
            drive("multsat", 3'd7, 3'd3, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            drive("prod_q11", 3'd7, 3'd6, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (tb_chk) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL sb_empty: DUT output presented with no expected entry queued");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_dst) begin
                    n_vec++;
                    if (dst !== mon_e.exp_dst) begin
                        n_fail++;
                        $display("FAIL %s dst: got %h want %h", mon_e.name, dst, mon_e.exp_dst);
                    end
                end
                if (mon_e.chk_prod) begin
                    n_vec++;
                    if (c_prod !== mon_e.exp_prod) begin
                        n_fail++;
                        $display("FAIL %s c_prod: got %b want %b", mon_e.name, c_prod, mon_e.exp_prod);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  as, bs;
        logic [6:0]  ld;
        int          r;
        logic [13:0] edge_v [4];
        edge_v[0] = 14'h1FFF; edge_v[1] = 14'h2000; edge_v[2] = 14'h0000; edge_v[3] = 14'h3FFF;

        rst_n = 1'b0;
        eep_rd_data = '0; xmeas = '0; cfg_data = '0;
        c_asel = 3'd7; c_bsel = 3'd3; c_subtract = 1'b0;
        c_err = 0; c_duty = 0; c_sumerr = 0; c_diferr = 0; c_xset = 0; c_preverr = 0; c_pid = 0;
        c_init_prod = 0; c_multsat = 0; c_clr_duty = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: every register reads back zero through the muxes.
        drive("rst_zero", 3'd7, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("rst_err", 3'd2, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_duty", 3'd4, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_sumerr", 3'd5, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_diferr", 3'd6, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_xset", 3'd7, 3'd0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_preverr", 3'd7, 3'd2, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_pid", 3'd7, 3'd4, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("rst_prod", 3'd7, 3'd6, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        eep_rd_data = 14'h0555;
        drive("pid_load", 3'd7, 3'd7, 1'b0, 7'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("pid_rd", 3'd7, 3'd4, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xmeas = 14'h0666;
        drive("err_load", 3'd1, 3'd0, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("err_rd", 3'd2, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("const_k", 3'd7, 3'd5, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        mult(14'h0555, 14'h0666, 14);
        mult(14'h1FFF, 14'h1FFF, 14);
        mult(14'h1FFF, 14'h2000, 14);
        mult(14'h2000, 14'h2000, 14);
        mult(14'h3FFF, 14'h2001, 14);

        xmeas = 14'h1FFF; eep_rd_data = 14'h0001;
        drive("add_pos_edge", 3'd1, 3'd7, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xmeas = 14'h2000;
        drive("sub_neg_edge", 3'd1, 3'd7, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xmeas = 14'h0123;
        drive("duty_load", 3'd1, 3'd3, 1'b0, 7'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("duty_rd", 3'd4, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("duty_clr_pri", 3'd1, 3'd3, 1'b0, 7'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("duty_rd0", 3'd4, 3'd3, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        xmeas = 14'h0A0B;
        drive("multi_load", 3'd1, 3'd3, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive("multi_rd", 3'd5, 3'd2, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 6));
            as = (r >= 3) ? 3'(r + 1) : 3'(r);
            bs = 3'($urandom_range(0, 7));
            ld = 7'($urandom & $urandom);
            cfg_data    = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 14'($urandom);
            xmeas       = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 14'($urandom);
            eep_rd_data = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 14'($urandom);
            drive("rand_op", as, bs, 1'($urandom), ld, 1'b0, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), 1'b1, 1'b1);
            if (n % 30 == 29)
                mult(14'($urandom), 14'($urandom), 14);
        end

        // Reset during a multiply must abort it and clear the product.
        mult(14'h0ABC, 14'h1357, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive("abort_prod", 3'd7, 3'd6, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("abort_pid", 3'd7, 3'd4, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        mult(14'h0555, 14'h0666, 14);

        repeat (2) @(posedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
